// File: rtl/sn74xxxx_pkg.sv
// Shared definitions for the SN74xxxx-class logic replicas: default widths,
// synchroniser limits and the byte type used on parallel ports.
package sn74xxxx_pkg;

    localparam int SN74_DEFAULT_WIDTH = 8;
    localparam int SN74_MIN_SYNC      = 2;

    typedef logic [SN74_DEFAULT_WIDTH-1:0] sn74_byte_t;

    // Metastability chains shorter than the minimum are silently stretched.
    function automatic int sn74_sync_depth(input int requested);
        return (requested < SN74_MIN_SYNC) ? SN74_MIN_SYNC : requested;
    endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// Samples one chip clock pin plus the data pins that must stay aligned with it,
// and flags the pin's rising edge in the system clock domain.
module pin_sync_edge
    import sn74xxxx_pkg::*;
#(
    parameter bit SYNC_EN     = 1'b0,
    parameter int SYNC_STAGES = SN74_MIN_SYNC,
    parameter int SIDE_W      = 1
) (
    input  logic              C,
    input  logic              nR,
    input  logic              pin_i,
    input  logic [SIDE_W-1:0] side_i,
    output logic [SIDE_W-1:0] side_o,
    output logic              rise_o
);

    localparam int STAGES = SYNC_EN ? sn74_sync_depth(SYNC_STAGES) : 1;
    localparam int LANE_W = SIDE_W + 1;

    // Each stage carries the clock pin in the MSB and its side pins below it.
    logic [STAGES-1:0][LANE_W-1:0] pipe_q, pipe_d;
    logic                          hist_q, hist_d;
    logic                          pin_p;

    assign pin_p  = pipe_q[STAGES-1][LANE_W-1];
    assign side_o = pipe_q[STAGES-1][SIDE_W-1:0];
    assign rise_o = pin_p & ~hist_q;

    always_comb begin
        // NOTE: every combinational output gets a value on every path, otherwise a latch is inferred.
        pipe_d[0] = {pin_i, side_i};
        for (int i = 1; i < STAGES; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        hist_d = pin_p;
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge C) begin
        if (!nR) begin
            // Everything resets high, so a pin that is already high at release shows no edge.
            pipe_q <= '1;
            hist_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
            pipe_q <= pipe_d;
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/shift_register_74595.sv
// SN74HC595-style serial-in/parallel-out register with storage latch, running on
// one system clock. Define SHIFT_REG_74595_SYNC_EN to add metastability chains on the pins.
module shift_register_74595
    import sn74xxxx_pkg::*;
#(
    parameter int WIDTH       = SN74_DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             C,
    input  logic             nR,
    input  logic             ser,
    input  logic             srclk,
    input  logic             rclk,
    input  logic             srclr_n,
    input  logic             oe_n,
    output logic [WIDTH-1:0] q,
    output logic             qh_s
);

`ifdef SHIFT_REG_74595_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    logic             ser_p, srclr_n_p, oe_n_p;
    logic             rise_s, rise_r;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] st_q, st_d;

    // ser and srclr_n ride the SRCLK chain; oe_n rides the RCLK chain, so every
    // pin sees the same pipeline depth.
    pin_sync_edge #(
        .SYNC_EN     (SYNC_EN),
        .SYNC_STAGES (SYNC_STAGES),
        .SIDE_W      (2)
    ) u_srclk_sync (
        .C      (C),
        .nR     (nR),
        .pin_i  (srclk),
        .side_i ({ser, srclr_n}),
        .side_o ({ser_p, srclr_n_p}),
        .rise_o (rise_s)
    );

    pin_sync_edge #(
        .SYNC_EN     (SYNC_EN),
        .SYNC_STAGES (SYNC_STAGES),
        .SIDE_W      (1)
    ) u_rclk_sync (
        .C      (C),
        .nR     (nR),
        .pin_i  (rclk),
        .side_i (oe_n),
        .side_o (oe_n_p),
        .rise_o (rise_r)
    );

    always_comb begin
        sr_d = sr_q;
        if (!srclr_n_p) begin
            sr_d = '0;
        end else if (rise_s) begin
            sr_d = {sr_q[WIDTH-2:0], ser_p};
        end
        // Storage takes the pre-shift value, giving the datasheet one-stage lag with tied clocks.
        st_d = rise_r ? sr_q : st_q;
    end

    always_ff @(posedge C) begin
        if (!nR) begin
            sr_q <= '0;
            st_q <= '0;
        end else begin
            sr_q <= sr_d;
            st_q <= st_d;
        end
    end

    assign q    = oe_n_p ? '0 : st_q;
    assign qh_s = sr_q[WIDTH-1];

endmodule

// File: tb/tb_shift_register_74595.sv
// Self-checking bench for shift_register_74595: a shift/latch vector table plus
// hand sequences, with expectations queued at drive time and checked when due.
module tb_shift_register_74595;
    import sn74xxxx_pkg::*;

    localparam int W = SN74_DEFAULT_WIDTH;
`ifdef SHIFT_REG_74595_SYNC_EN
    localparam int PIN_LAT = 3;
    localparam int OE_LAT  = 2;
`else
    localparam int PIN_LAT = 2;
    localparam int OE_LAT  = 1;
`endif

    logic       C = 1'b0;
    logic       nR = 1'b0;
    logic       ser = 1'b0;
    logic       srclk = 1'b0;
    logic       rclk = 1'b0;
    logic       srclr_n = 1'b1;
    logic       oe_n = 1'b1;
    sn74_byte_t q;
    logic       qh_s;

    shift_register_74595 #(
        .WIDTH       (W),
        .SYNC_STAGES (2)
    ) dut (
        .C       (C),
        .nR      (nR),
        .ser     (ser),
        .srclk   (srclk),
        .rclk    (rclk),
        .srclr_n (srclr_n),
        .oe_n    (oe_n),
        .q       (q),
        .qh_s    (qh_s)
    );

    always #5 C = ~C;

    int cyc = 0;
    always @(posedge C) cyc++;

    typedef struct {
        int         due;
        sn74_byte_t q;
        logic       qh;
        bit         chk_qh;
        string      name;
    } exp_t;

    typedef struct {
        logic       s;
        logic       sc;
        logic       rc;
        sn74_byte_t q;
        logic       qh;
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Scoreboard: compare every expectation whose cycle has come, away from the active edge.
    always @(negedge C) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                n_vec++;
                if (sb[i].due < cyc) begin
                    n_err++;
                    $display("FAIL %s: check slot %0d missed, now cycle %0d", sb[i].name, sb[i].due, cyc);
                end else if (q !== sb[i].q || (sb[i].chk_qh && qh_s !== sb[i].qh)) begin
                    n_err++;
                    $display("FAIL %s (cycle %0d): got q=%h qh_s=%b, required q=%h qh_s=%b%s",
                             sb[i].name, cyc, q, qh_s, sb[i].q, sb[i].qh,
                             sb[i].chk_qh ? "" : " (qh_s not checked)");
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge C);
            #1;
        end
    endtask

    task automatic push_exp(input int k, input sn74_byte_t eq, input logic eqh,
                            input bit cq, input string nm);
        exp_t e;
        e.due    = cyc + k;
        e.q      = eq;
        e.qh     = eqh;
        e.chk_qh = cq;
        e.name   = nm;
        sb.push_back(e);
    endtask

    task automatic shift_bit(input logic b);
        ser   = b;
        srclk = 1'b1;
        tick();
        srclk = 1'b0;
        tick();
    endtask

    task automatic shift_byte(input sn74_byte_t v);
        for (int i = W - 1; i >= 0; i--) shift_bit(v[i]);
    endtask

    task automatic pulse_rclk();
        rclk = 1'b1;
        tick();
        rclk = 1'b0;
        tick();
    endtask

    initial begin
        vec_t       tbl[$];
        sn74_byte_t pat;
        sn74_byte_t tied_pat;
        logic       b;

        // Shift-and-latch table: expectations are the settled outputs PIN_LAT edges after each row.
        pat = 8'b1011_0010;
        for (int k = 0; k < W; k++) begin
            tbl.push_back('{pat[W-1-k], 1'b1, 1'b0, 8'h00, (k == W - 1) ? 1'b1 : 1'b0});
            tbl.push_back('{pat[W-1-k], 1'b0, 1'b0, 8'h00, (k == W - 1) ? 1'b1 : 1'b0});
        end
        tbl.push_back('{1'b0, 1'b0, 1'b1, 8'hB2, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 8'hB2, 1'b1});

        tick();

        // Reset held while the clock pins toggle with ser=1.
        nR = 1'b0; ser = 1'b1; oe_n = 1'b0; srclr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            srclk = ~srclk;
            rclk  = ~rclk;
            push_exp(1, 8'h00, 1'b0, 1'b1, "reset_hold");
            tick();
        end
        srclk = 1'b1; rclk = 1'b0;
        push_exp(1, 8'h00, 1'b0, 1'b1, "reset_hold");
        tick();

        // Release with srclk already high: no edge, sr stays empty.
        nR = 1'b1;
        push_exp(1, 8'h00, 1'b0, 1'b1, "post_reset_first");
        tick();
        for (int i = 0; i < 3; i++) begin
            push_exp(1, 8'h00, 1'b0, 1'b1, "release_no_shift");
            tick();
        end
        srclk = 1'b0;
        tick(2);
        push_exp(PIN_LAT, 8'h00, 1'b0, 1'b1, "release_sr_zero");
        pulse_rclk();
        tick(2);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rc && !rclk) push_exp(PIN_LAT - 1, 8'h00, 1'b0, 1'b0, "latch_not_early");
            ser   = tbl[i].s;
            srclk = tbl[i].sc;
            rclk  = tbl[i].rc;
            push_exp(PIN_LAT, tbl[i].q, tbl[i].qh, 1'b1, $sformatf("shift_row%0d", i));
            tick();
        end
        tick(2);

        // Clear: coincides with a shift pulse and must win; storage untouched.
        shift_byte(8'hFF);
        push_exp(PIN_LAT, 8'hFF, 1'b1, 1'b1, "load_ff");
        pulse_rclk();
        tick(2);
        srclr_n = 1'b0;
        push_exp(PIN_LAT, 8'hFF, 1'b0, 1'b1, "clear_beats_shift");
        shift_bit(1'b1);
        srclr_n = 1'b1;
        tick(2);
        push_exp(PIN_LAT, 8'h00, 1'b0, 1'b1, "latch_after_clear");
        pulse_rclk();
        tick(2);

        // Shift, latch and clear all in one cycle: storage takes the old sr.
        shift_byte(8'hC3);
        push_exp(1, 8'h00, 1'b1, 1'b1, "c3_loaded");
        tick();
        ser = 1'b0; srclk = 1'b1; rclk = 1'b1; srclr_n = 1'b0;
        push_exp(PIN_LAT, 8'hC3, 1'b0, 1'b1, "simul_old_sr");
        tick();
        srclk = 1'b0; rclk = 1'b0; srclr_n = 1'b1;
        tick(2);
        push_exp(PIN_LAT, 8'h00, 1'b0, 1'b1, "simul_sr_cleared");
        pulse_rclk();
        tick(2);

        // Tied clocks: storage lags the shift register by one stage.
        tied_pat = 8'hA5;
        for (int i = 0; i < W + 1; i++) begin
            b = (i < W) ? tied_pat[W-1-i] : 1'b0;
            ser = b; srclk = 1'b1; rclk = 1'b1;
            if (i == 0)     push_exp(PIN_LAT, 8'h00, 1'b0, 1'b1, "tied_first");
            if (i == W - 1) push_exp(PIN_LAT, 8'h52, 1'b1, 1'b1, "tied_eighth");
            if (i == W)     push_exp(PIN_LAT, 8'hA5, 1'b0, 1'b1, "tied_ninth");
            tick();
            srclk = 1'b0; rclk = 1'b0;
            tick();
        end
        tick(2);

        // Output enable: disabled q reads 0, storage keeps updating underneath.
        shift_byte(8'h3C);
        push_exp(PIN_LAT, 8'h3C, 1'b0, 1'b1, "oe_base");
        pulse_rclk();
        tick(2);
        oe_n = 1'b1;
        push_exp(OE_LAT - 1, 8'h3C, 1'b0, 1'b0, "oe_still_on");
        push_exp(OE_LAT, 8'h00, 1'b0, 1'b0, "oe_off");
        tick();
        shift_byte(8'hC5);
        push_exp(PIN_LAT, 8'h00, 1'b1, 1'b1, "oe_hidden_qh_live");
        pulse_rclk();
        tick(2);
        oe_n = 1'b0;
        push_exp(OE_LAT, 8'hC5, 1'b1, 1'b1, "oe_on_updated");
        tick(2);

        // Reset mid-stream throws away partial shifts and storage.
        for (int i = 0; i < 3; i++) shift_bit(1'b1);
        nR = 1'b0;
        push_exp(1, 8'h00, 1'b0, 1'b1, "mid_reset");
        tick();
        nR = 1'b1;
        tick(2);
        for (int i = 0; i < 4; i++) shift_bit(1'b1);
        push_exp(PIN_LAT, 8'h0F, 1'b0, 1'b1, "after_mid_reset");
        pulse_rclk();

        for (int t = 0; t < 50 && sb.size() > 0; t++) tick();
        while (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: check never reached, due cycle %0d", sb[0].name, sb[0].due);
            void'(sb.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
